// File: rtl/gpio_reg_bank.sv
// GPIO-strobed register bank: trigger pulses plus byte-serial wide config registers.
// Define GPIO_READBACK_EN to add the byte-wise readback shift path.
module gpio_reg_bank #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 8,
    parameter int                REG_W     = 32,
    parameter logic [ADDR_W-1:0] REG_BASE  = 16'h0020,
    parameter int                NUM_TRIG  = 2,
    parameter logic [ADDR_W-1:0] TRIG_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] RD_BASE   = 16'h0040
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W+DATA_W:0]       gpio_in,
    output logic [NUM_REGS*REG_W-1:0]    cfg_regs,
    output logic [NUM_REGS-1:0]          cfg_valid,
    output logic [NUM_TRIG-1:0]          trig_out,
    output logic                         seq_err,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid
);
    localparam int IN_W  = ADDR_W + DATA_W + 1;
    localparam int BPR   = REG_W / DATA_W;
    localparam int CNT_W = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPR - 1);

    logic [IN_W-1:0] sync1_q, sync2_q;
    logic            prev_q;
    logic [1:0]      arm_q, arm_d;

    // Whole bus is synchronized together; arm_q blocks events until prev_q has seen a real synced strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= 1'b0;
            arm_q   <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q[IN_W-1];
            arm_q   <= arm_d;
        end
    end

    always_comb arm_d = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

    logic [ADDR_W-1:0] addr_s, trig_off, reg_off;
    logic [DATA_W-1:0] data_s;
    logic              wr_ev, trig_hit, reg_hit;
    logic [IDX_W-1:0]  reg_idx;

    always_comb begin
        addr_s   = sync2_q[ADDR_W-1:0];
        data_s   = sync2_q[ADDR_W +: DATA_W];
        wr_ev    = sync2_q[IN_W-1] && !prev_q && (arm_q == 2'd3);
        trig_off = addr_s - TRIG_BASE;
        reg_off  = addr_s - REG_BASE;
        trig_hit = wr_ev && (trig_off < ADDR_W'(NUM_TRIG));
        reg_hit  = wr_ev && (reg_off < ADDR_W'(NUM_REGS));
        reg_idx  = reg_off[IDX_W-1:0];
    end

    logic [REG_W-1:0]    shadow_q, shadow_d, shifted;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_eff;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [REG_W-1:0]    regs_q [NUM_REGS];
    logic [REG_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] cfg_valid_q, cfg_valid_d;
    logic [NUM_TRIG-1:0] trig_q, trig_d;
    logic                seq_err_q, seq_err_d;

    always_comb begin
        // NOTE: every _d takes a default first, so no path through this block can infer a latch.
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        regs_d      = regs_q;
        cfg_valid_d = '0;
        trig_d      = '0;
        seq_err_d   = 1'b0;
        cnt_eff     = '0;
        shifted     = (shadow_q << DATA_W) | REG_W'(data_s);
        for (int j = 0; j < NUM_TRIG; j++) begin
            trig_d[j] = trig_hit && (trig_off == ADDR_W'(j));
        end
        if (reg_hit) begin
            // A byte for a different register abandons the partial sequence and restarts at byte 0.
            if (cnt_q != '0 && reg_idx != idx_q) begin
                seq_err_d = 1'b1;
            end else begin
                cnt_eff = cnt_q;
            end
            if (cnt_eff == LAST_BYTE) begin
                regs_d[reg_idx]      = shifted;
                cfg_valid_d[reg_idx] = 1'b1;
                cnt_d                = '0;
            end else begin
                cnt_d = cnt_eff + CNT_W'(1);
            end
            shadow_d = shifted;
            idx_d    = reg_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            cfg_valid_q <= '0;
            trig_q      <= '0;
            seq_err_q   <= 1'b0;
            // NOTE: the register array is reset because cfg_regs must read zero out of reset.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            cfg_valid_q <= cfg_valid_d;
            trig_q      <= trig_d;
            seq_err_q   <= seq_err_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) cfg_regs[i*REG_W +: REG_W] = regs_q[i];
    end

    assign cfg_valid = cfg_valid_q;
    assign trig_out  = trig_q;
    assign seq_err   = seq_err_q;

`ifdef GPIO_READBACK_EN
    logic [REG_W-1:0]  rb_q, rb_d;
    logic [CNT_W-1:0]  rb_cnt_q, rb_cnt_d;
    logic              rb_valid_q, rb_valid_d;
    logic [ADDR_W-1:0] rd_off;

    always_comb begin
        rb_d       = rb_q;
        rb_cnt_d   = rb_cnt_q;
        rb_valid_d = rb_valid_q;
        rd_off     = addr_s - RD_BASE;
        if (wr_ev && rd_off == '0 && 32'(data_s) < NUM_REGS) begin
            rb_d       = regs_q[data_s[IDX_W-1:0]];
            rb_cnt_d   = '0;
            rb_valid_d = 1'b1;
        end else if (wr_ev && rd_off == ADDR_W'(1) && rb_valid_q) begin
            // Advancing past the last byte empties the register so rd_data drops to zero.
            if (rb_cnt_q == LAST_BYTE) begin
                rb_d       = '0;
                rb_cnt_d   = '0;
                rb_valid_d = 1'b0;
            end else begin
                rb_d     = rb_q << DATA_W;
                rb_cnt_d = rb_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_q       <= '0;
            rb_cnt_q   <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_q       <= rb_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rd_data  = rb_q[REG_W-1 -: DATA_W];
    assign rd_valid = rb_valid_q;
`else
    assign rd_data  = '0;
    assign rd_valid = 1'b0;
`endif

endmodule

// File: doc/gpio_reg_bank.md
GPIO_REG_BANK -- requirements
Module: gpio_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: GPIO address field width.
REQ-002 SHALL have parameter DATA_W, default 8: GPIO data field width, and the byte size for shifting.
REQ-003 SHALL have parameter NUM_REGS, default 8: number of wide config registers.
REQ-004 SHALL have parameter REG_W, default 32: width of each register; must be an integer multiple of DATA_W, ≥ DATA_W.
REQ-005 SHALL have parameter REG_BASE, default 16'h0020: register i write address is REG_BASE+i.
REQ-006 SHALL have parameter NUM_TRIG, default 2: trigger pulse count; trigger j address is TRIG_BASE+j.
REQ-007 SHALL have parameter TRIG_BASE, default 16'h0000.
REQ-008 SHALL have parameter RD_BASE, default 16'h0040: RD_BASE = readback load address; RD_BASE+1 = readback advance address.
REQ-009 SHALL have port clk, input, 1 bit: single clock.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-011 SHALL have port gpio_in, input, ADDR_W+DATA_W+1 bits: [ADDR_W-1:0] address, [ADDR_W+DATA_W-1:ADDR_W] data, MSB write strobe (w_clk).
REQ-012 SHALL have port cfg_regs, output, NUM_REGS*REG_W bits: committed registers, with register i at [i*REG_W +: REG_W].
REQ-013 SHALL have port cfg_valid, output, NUM_REGS bits: one-cycle commit pulse per register.
REQ-014 SHALL have port trig_out, output, NUM_TRIG bits: one-cycle trigger pulses.
REQ-015 SHALL have port seq_err, output, 1 bit: one-cycle pulse on an abandoned byte sequence.
REQ-016 SHALL have port rd_data, output, DATA_W bits: current readback byte.
REQ-017 SHALL have port rd_valid, output, 1 bit: level signal, high while rd_data holds a loaded byte.

Function
REQ-018 SHALL pass all of gpio_in through a 2-stage synchronizer plus one previous-strobe register; a write event is synced strobe high AND previous low.
REQ-019 SHALL take all register-visible effects of a write event on the 3rd rising clk edge after gpio_in strobe is first sampled high.
REQ-020 SHALL generate exactly one write event per strobe rising edge; strobe held high, or a strobe falling edge, SHALL produce no event.
REQ-021 SHALL, on a write to TRIG_BASE+j, pulse trig_out[j] for exactly one cycle, with the data field ignored.
REQ-022 SHALL, on a write to REG_BASE+i, shift the byte into a shared shadow register MSB-first: shadow <= {shadow[REG_W-DATA_W-1:0], data}.
REQ-023 SHALL track the target index and a byte counter (0..REG_W/DATA_W-1) for the shared shadow.
REQ-024 SHALL, when the REG_W/DATA_W-th consecutive byte to the same index arrives, copy the shadow with that byte into cfg_regs[i], pulse cfg_valid[i] for 1 cycle, and clear the counter.
REQ-025 SHALL, on a write to REG_BASE+k with k ≠ the tracked index and counter ≠ 0, pulse seq_err, discard the prior bytes, and take this byte as byte 0 of register k.
REQ-026 SHALL treat a write to an unmapped address as a no-op that leaves the counter unchanged.
REQ-027 SHALL, when REG_W == DATA_W, commit on every single write.
REQ-028 SHALL hold all outputs when no write event occurs; cfg_regs changes only on commit.

Reset
REQ-029 SHALL, while rst is low, asynchronously clear the synchronizers, shadow, counter, and tracked index, and set cfg_regs, cfg_valid, trig_out, seq_err, rd_data, and rd_valid to 0.
REQ-030 SHALL, when reset is asserted mid-sequence, lose any partial bytes, so the first write after reset is byte 0.
REQ-031 SHALL NOT generate a write event from a strobe already high at reset release; the previous-strobe register SHALL be set from the synced strobe during the first cycles after release.

Configuration
REQ-032 SHALL gate readback with macro GPIO_READBACK_EN.
REQ-033 SHALL, with GPIO_READBACK_EN defined, on a write to RD_BASE with data = index n < NUM_REGS, load readback shift register from cfg_regs[n], present its top byte on rd_data, and set rd_valid=1.
REQ-034 SHALL, with GPIO_READBACK_EN defined, on each write to RD_BASE+1, shift the readback register left by DATA_W, after REG_W/DATA_W-1 shifts leave rd_valid=0 with rd_data=0 on the next advance, and treat n ≥ NUM_REGS as a no-op.
REQ-035 SHALL, without GPIO_READBACK_EN, have no readback logic, tie rd_data=0 and rd_valid=0, and treat RD_BASE and RD_BASE+1 as unmapped.

Verification
REQ-036 SHALL cover trigger: write addr 0x0001 → trig_out=2'b10 for exactly 1 cycle, on the 3rd edge after strobe.
REQ-037 SHALL cover commit: bytes 0xDE,0xAD,0xBE,0xEF to 0x0023 → cfg_regs[3]=0xDEADBEEF, cfg_valid=8'h08 for 1 cycle.
REQ-038 SHALL cover abandonment: 2 bytes to 0x0020, then 0xAA to 0x0021 → seq_err pulse; then 0x11,0x22,0x33 to 0x0021 → cfg_regs[1]=0xAA112233, cfg_regs[0] unchanged.
REQ-039 SHALL cover held strobe: strobe high for 20 cycles on addr 0x0000 → exactly one trig_out[0] pulse.
REQ-040 SHALL cover reset mid-sequence: 3 bytes to 0x0022, assert rst, then 4 bytes 0x01..0x04 → cfg_regs[2]=0x01020304.
REQ-041 SHALL cover readback (macro defined): after REQ-037, write 0x0040 data 3 → rd_data=0xDE; three writes to 0x0041 → 0xAD, 0xBE, 0xEF; a fourth → rd_valid=0.
